can_bitstream_destuff: RTL and testbench

//  Parametrised successor to the CAN destuffer. Samples the raw serial CAN bus, hard-syncs on SOF,

---
 rtl/can_pkg.sv | 25 ++
 rtl/can_bit_timer.sv | 54 +++++
 rtl/can_bitstream_destuff.sv | 208 ++++++++++++++++++++
 tb/tb_can_bitstream_destuff.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : can_pkg
//  Purpose  : Shared definitions for the CAN bitstream destuffer: destuff FSM
//             state encoding, bus level constants and the default stuff
//             run length.
//  Revision : 1.0  initial release
// ============================================================================
package can_pkg;

  // Destuff FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  localparam logic c_RECESSIVE = 1'b1;
  localparam logic c_DOMINANT  = 1'b0;

  // Equal-bit run length after which a complementary stuff bit must follow
  localparam int c_CAN_STUFF_LEN = 5;

endpackage : can_pkg
`default_nettype wire

// File: rtl/can_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : can_bit_timer
//  Purpose  : Nominal bit-time counter. Counts 0..CLKS_PER_BIT-1 while running
//             and is forced to 0 by a hard-sync request or while stopped.
//             Flags the clocks at SAMPLE_POINT-1, SAMPLE_POINT, SAMPLE_POINT+1.
//  Ports    : i_Clock      system clock
//             i_Reset      synchronous active-high reset
//             i_Sync       hard sync: counter restarts from 0
//             i_Run        counter enable (low holds counter at 0)
//             o_Tick_Pre   counter == SAMPLE_POINT-1
//             o_Tick_Mid   counter == SAMPLE_POINT
//             o_Tick_Post  counter == SAMPLE_POINT+1
//  Revision : 1.0  initial release
// ============================================================================
module can_bit_timer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int SAMPLE_POINT = 7
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Sync,
  input  logic i_Run,
  output logic o_Tick_Pre,
  output logic o_Tick_Mid,
  output logic o_Tick_Post
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [TW-1:0] c_CNT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] c_SP_PRE   = TW'(SAMPLE_POINT - 1);
  localparam logic [TW-1:0] c_SP_MID   = TW'(SAMPLE_POINT);
  localparam logic [TW-1:0] c_SP_POST  = TW'(SAMPLE_POINT + 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Sync || !i_Run) begin
      r_count <= '0;
    end else if (r_count == c_CNT_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + TW'(1);
    end
  end

  // Gated by i_Run so a held-at-zero counter never produces spurious ticks
  assign o_Tick_Pre  = i_Run && (r_count == c_SP_PRE);
  assign o_Tick_Mid  = i_Run && (r_count == c_SP_MID);
  assign o_Tick_Post = i_Run && (r_count == c_SP_POST);

endmodule : can_bit_timer
`default_nettype wire

// File: rtl/can_bitstream_destuff.sv
`default_nettype none
// ============================================================================
//  Module   : can_bitstream_destuff
//  Purpose  : Samples the raw CAN bus, hard-syncs on SOF, removes stuff bits
//             and flags stuff errors. Produces a destuffed data-bit stream.
//  Config   : CAN_DESTUFF_TRIPLE_SAMPLE_EN - majority of three samples around
//             the sample point, decision one clock later. Undefined: single
//             sample at SAMPLE_POINT.
//  Ports    : i_Clock        system clock
//             i_Reset        synchronous active-high reset
//             i_Serial       raw bus level (1 = recessive)
//             i_Enable       stuffing region active
//             o_Bit_Valid    strobe: o_Bit holds a destuffed data bit
//             o_Bit          destuffed data bit
//             o_Stuff_Skip   strobe: sampled bit was a stuff bit
//             o_Stuff_Error  strobe: STUFF_LEN+1 equal bits sampled
//             o_Error_Flag   sticky error until reset or i_Enable low
//             o_Bit_Count    data bits delivered since SOF, saturating
//  Revision : 1.0  initial release
// ============================================================================
module can_bitstream_destuff
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int SAMPLE_POINT = 7,
  parameter int STUFF_LEN    = c_CAN_STUFF_LEN,
  parameter int CNT_W        = 8
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Serial,
  input  logic             i_Enable,
  output logic             o_Bit_Valid,
  output logic             o_Bit,
  output logic             o_Stuff_Skip,
  output logic             o_Stuff_Error,
  output logic             o_Error_Flag,
  output logic [CNT_W-1:0] o_Bit_Count
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);
  localparam logic [RUN_W-1:0] c_RUN_MAX = RUN_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  // Input synchroniser plus one history flop for SOF edge detection
  logic r_ser_meta, r_ser_s, r_ser_prev;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_ser_meta <= c_RECESSIVE;
      r_ser_s    <= c_RECESSIVE;
      r_ser_prev <= c_RECESSIVE;
    end else begin
      r_ser_meta <= i_Serial;
      r_ser_s    <= r_ser_meta;
      r_ser_prev <= r_ser_s;
    end
  end

  state_t           r_state, w_state_next;
  logic [RUN_W-1:0] r_run, w_run_next;
  logic             r_last, w_last_next;
  logic             r_bit_valid, w_bit_valid_next;
  logic             r_bit, w_bit_next;
  logic             r_skip, w_skip_next;
  logic             r_err, w_err_next;
  logic             r_flag, w_flag_next;
  logic [CNT_W-1:0] r_count, w_count_next;

  logic w_hard_sync;
  logic w_tick_pre, w_tick_mid, w_tick_post;
  logic w_tick;
  logic w_sample;

  assign w_hard_sync = (r_state == ST_IDLE) && i_Enable && r_ser_prev && !r_ser_s;

  can_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_timer (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Sync      (w_hard_sync),
    .i_Run       (r_state == ST_ACTIVE),
    .o_Tick_Pre  (w_tick_pre),
    .o_Tick_Mid  (w_tick_mid),
    .o_Tick_Post (w_tick_post)
  );

`ifdef CAN_DESTUFF_TRIPLE_SAMPLE_EN
  // Hold the two earlier samples; the third is live ser_s at SAMPLE_POINT+1
  logic r_smp_pre, r_smp_mid;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_smp_pre <= c_RECESSIVE;
      r_smp_mid <= c_RECESSIVE;
    end else begin
      if (w_tick_pre) r_smp_pre <= r_ser_s;
      if (w_tick_mid) r_smp_mid <= r_ser_s;
    end
  end

  assign w_tick   = w_tick_post;
  assign w_sample = (r_smp_pre & r_smp_mid) | (r_smp_pre & r_ser_s) | (r_smp_mid & r_ser_s);
`else
  logic w_unused_ticks;
  assign w_unused_ticks = w_tick_pre | w_tick_post;

  assign w_tick   = w_tick_mid;
  assign w_sample = r_ser_s;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state     <= ST_IDLE;
      r_run       <= '0;
      r_last      <= c_DOMINANT;
      r_bit_valid <= 1'b0;
      r_bit       <= c_RECESSIVE;
      r_skip      <= 1'b0;
      r_err       <= 1'b0;
      r_flag      <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_run       <= w_run_next;
      r_last      <= w_last_next;
      r_bit_valid <= w_bit_valid_next;
      r_bit       <= w_bit_next;
      r_skip      <= w_skip_next;
      r_err       <= w_err_next;
      r_flag      <= w_flag_next;
      r_count     <= w_count_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_run_next       = r_run;
    w_last_next      = r_last;
    w_bit_valid_next = 1'b0;
    w_bit_next       = r_bit;
    w_skip_next      = 1'b0;
    w_err_next       = 1'b0;
    w_flag_next      = r_flag;
    w_count_next     = r_count;

    case (r_state)
      ST_IDLE: begin
        w_flag_next = 1'b0;
        if (w_hard_sync) begin
          w_state_next = ST_ACTIVE;
          w_run_next   = '0;
          w_count_next = '0;
        end
      end

      ST_ACTIVE: begin
        // Enable fall wins over a coincident tick
        if (!i_Enable) begin
          w_state_next = ST_IDLE;
          w_flag_next  = 1'b0;
        end else if (w_tick) begin
          if (r_run == c_RUN_MAX) begin
            if (w_sample != r_last) begin
              // Stuff bit starts the next run
              w_skip_next = 1'b1;
              w_run_next  = RUN_W'(1);
              w_last_next = w_sample;
            end else begin
              w_err_next   = 1'b1;
              w_flag_next  = 1'b1;
              w_state_next = ST_ERROR;
            end
          end else begin
            w_bit_valid_next = 1'b1;
            w_bit_next       = w_sample;
            if (r_count != c_CNT_MAX) w_count_next = r_count + CNT_W'(1);
            // run==0 only right after SOF sync, so SOF always yields run=1
            w_run_next  = (w_sample == r_last) ? r_run + RUN_W'(1) : RUN_W'(1);
            w_last_next = w_sample;
          end
        end
      end

      ST_ERROR: begin
        if (!i_Enable) begin
          w_state_next = ST_IDLE;
          w_flag_next  = 1'b0;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_Bit_Valid   = r_bit_valid;
  assign o_Bit         = r_bit;
  assign o_Stuff_Skip  = r_skip;
  assign o_Stuff_Error = r_err;
  assign o_Error_Flag  = r_flag;
  assign o_Bit_Count   = r_count;

endmodule : can_bitstream_destuff
`default_nettype wire

// File: tb/tb_can_bitstream_destuff.sv
`default_nettype none
// ============================================================================
//  Module   : tb_can_bitstream_destuff
//  Purpose  : Directed self-checking bench for can_bitstream_destuff with the
//             default parameters (10 clocks/bit, sample point 7, run 5).
//  Revision : 1.0  initial release
// ============================================================================
module tb_can_bitstream_destuff;

  localparam int CPB = 10;

  logic       clk;
  logic       rst;
  logic       ser;
  logic       en;
  logic       bit_valid;
  logic       bit_out;
  logic       stuff_skip;
  logic       stuff_err;
  logic       err_flag;
  logic [7:0] bit_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Strobe tallies gathered away from the active edge
  int mon_valid = 0;
  int mon_skip  = 0;
  int mon_err   = 0;
  int mon_multi = 0;

  int base_valid, base_skip, base_err;

  can_bitstream_destuff #(
    .CLKS_PER_BIT (CPB),
    .SAMPLE_POINT (7),
    .STUFF_LEN    (5),
    .CNT_W        (8)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Serial      (ser),
    .i_Enable      (en),
    .o_Bit_Valid   (bit_valid),
    .o_Bit         (bit_out),
    .o_Stuff_Skip  (stuff_skip),
    .o_Stuff_Error (stuff_err),
    .o_Error_Flag  (err_flag),
    .o_Bit_Count   (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bit_valid)  mon_valid <= mon_valid + 1;
    if (stuff_skip) mon_skip  <= mon_skip + 1;
    if (stuff_err)  mon_err   <= mon_err + 1;
    if ((int'(bit_valid) + int'(stuff_skip) + int'(stuff_err)) > 1) mon_multi <= mon_multi + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    base_valid = mon_valid;
    base_skip  = mon_skip;
    base_err   = mon_err;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) ser = b;
    repeat (CPB) @(posedge clk);
  endtask

  // Bit whose level is flipped for exactly the clock sampled at SAMPLE_POINT
  task automatic send_glitch_bit(input logic b);
    @(negedge clk) ser = b;
    repeat (8) @(posedge clk);
    @(negedge clk) ser = ~b;
    @(posedge clk);
    @(negedge clk) ser = b;
    @(posedge clk);
  endtask

  task automatic start_frame();
    @(negedge clk);
    en  = 1'b1;
    ser = 1'b1;
    repeat (4) @(posedge clk);
    snap();
  endtask

  // Let the last bit's strobe (single or triple-sample timing) land
  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic stop_frame();
    @(negedge clk) en = 1'b0;
    ser = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    ser = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_bit",       int'(bit_out),    1);
    chk("reset_valid",     int'(bit_valid),  0);
    chk("reset_skip",      int'(stuff_skip), 0);
    chk("reset_err",       int'(stuff_err),  0);
    chk("reset_flag",      int'(err_flag),   0);
    chk("reset_count",     int'(bit_count),  0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: alternating 0,1 x20
    start_frame();
    for (int i = 0; i < 20; i++) send_bit(i[0]);
    settle();
    chk("alt_valid", mon_valid - base_valid, 20);
    chk("alt_skip",  mon_skip - base_skip,   0);
    chk("alt_err",   mon_err - base_err,     0);
    chk("alt_count", int'(bit_count),        20);
    chk("alt_bit",   int'(bit_out),          1);
    stop_frame();

    // 2: SOF + four zeros, stuff 1, data 0
    start_frame();
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    settle();
    chk("stuff_valid", mon_valid - base_valid, 6);
    chk("stuff_skip",  mon_skip - base_skip,   1);
    chk("stuff_err",   mon_err - base_err,     0);
    chk("stuff_count", int'(bit_count),        6);
    chk("stuff_bit",   int'(bit_out),          0);
    stop_frame();

    // 3: six zeros -> stuff error, sticky until enable low
    start_frame();
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    settle();
    chk("serr_valid", mon_valid - base_valid, 5);
    chk("serr_err",   mon_err - base_err,     1);
    chk("serr_flag",  int'(err_flag),         1);
    send_bit(1'b1);
    send_bit(1'b1);
    settle();
    chk("serr_flag_hold",  int'(err_flag),         1);
    chk("serr_no_strobes", mon_valid - base_valid, 5);
    stop_frame();
    chk("serr_flag_clear", int'(err_flag),  0);
    chk("serr_count_kept", int'(bit_count), 5);

    // 4: SOF, 11111, stuff 0, 1111 -> run restarts, no error
    start_frame();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    settle();
    chk("restart_valid", mon_valid - base_valid, 10);
    chk("restart_skip",  mon_skip - base_skip,   1);
    chk("restart_err",   mon_err - base_err,     0);
    chk("restart_flag",  int'(err_flag),         0);
    chk("restart_count", int'(bit_count),        10);
    stop_frame();

    // 5: reset at clock 4 of bit 3
    start_frame();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk) ser = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("midrst_bit",   int'(bit_out),   1);
    chk("midrst_valid", int'(bit_valid), 0);
    chk("midrst_count", int'(bit_count), 0);
    chk("midrst_flag",  int'(err_flag),  0);
    rst = 1'b0;
    snap();
    repeat (4 * CPB) @(negedge clk);
    chk("midrst_quiet", (mon_valid - base_valid) + (mon_skip - base_skip) + (mon_err - base_err), 0);
    send_bit(1'b0);
    send_bit(1'b1);
    settle();
    chk("midrst_resync_valid", mon_valid - base_valid, 2);
    chk("midrst_resync_count", int'(bit_count),        2);
    stop_frame();

    // Enable fall in the tick cycle of bit 2: no strobe for it
    start_frame();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk) en = 1'b0;
    repeat (4) @(negedge clk);
    chk("enfall_valid", mon_valid - base_valid, 2);
    chk("enfall_count", int'(bit_count),        2);

    // 6: glitch at the sample point of the sixth zero
    start_frame();
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    send_glitch_bit(1'b0);
    settle();
    chk("glitch_valid", mon_valid - base_valid, 5);
`ifdef CAN_DESTUFF_TRIPLE_SAMPLE_EN
    chk("glitch_skip", mon_skip - base_skip, 0);
    chk("glitch_err",  mon_err - base_err,   1);
    chk("glitch_flag", int'(err_flag),       1);
`else
    chk("glitch_skip", mon_skip - base_skip, 1);
    chk("glitch_err",  mon_err - base_err,   0);
    chk("glitch_flag", int'(err_flag),       0);
`endif
    stop_frame();

    chk("one_strobe_per_cycle", mon_multi, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_can_bitstream_destuff
`default_nettype wire
